adder_share_arbiter: RTL

Time-shares one combinational 16-bit carry_lookahead_adder between N_REQ requesters in the home-automation datapath. Round-robin arbitration picks one requester and registers its operands onto the adder inputs. After a programmable settle time the block captures the 17-bit sum and returns it with a one-cycle acknowledge. The adder instance sits outside this block, wired through o_add1/o_add2/i_add_result.

---
 rtl/adder_share_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing of one external combinational adder between N_REQ requesters.
// Operands are frozen at grant; the sum is captured after SETTLE_CYC cycles and acked for one cycle.
module adder_share_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTH-1:0]     i_op_a,
    input  logic [N_REQ*WIDTH-1:0]     i_op_b,
    output logic [N_REQ-1:0]           o_ack,
    output logic [WIDTH:0]             o_sum,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_owner,
    output logic [WIDTH-1:0]           o_add1,
    output logic [WIDTH-1:0]           o_add2,
    input  logic [WIDTH:0]             i_add_result
);

    localparam int IDXW = $clog2(N_REQ);
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ACK
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]  add1_q, add1_d;
    logic [WIDTH-1:0]  add2_q, add2_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              grant_vld;
    logic [IDXW-1:0]   grant_idx;

    // Search starts just after the last served requester and wraps around.
    always_comb begin
        logic [IDXW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDXW'((32'(ptr_q) + off) % N_REQ);
            if (!grant_vld && i_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        add1_d  = add1_q;
        add2_d  = add2_q;
        sum_d   = sum_q;
        ack_d   = '0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    add1_d  = i_op_a[grant_idx*WIDTH +: WIDTH];
                    add2_d  = i_op_b[grant_idx*WIDTH +: WIDTH];
                    owner_d = grant_idx;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    sum_d          = i_add_result;
                    ack_d[owner_q] = 1'b1;
                    ptr_d          = owner_q;
                    state_d        = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IDXW'(N_REQ - 1);
            owner_q <= '0;
            add1_q  <= '0;
            add2_q  <= '0;
            sum_q   <= '0;
            ack_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            add1_q  <= add1_d;
            add2_q  <= add2_d;
            sum_q   <= sum_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ack   = ack_q;
    assign o_sum   = sum_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_owner = owner_q;
    assign o_add1  = add1_q;
    assign o_add2  = add2_q;

endmodule
